cache_line_ctrl: RTL

Initiator-side controller for the direct-mapped cache's valid-bit RAM and tag RAM.
- Drives their address, write-enable and write-data pins.
- Performs the hit/miss lookup and the refill handshake to memory.
- After reset, and on request, sweeps every line invalid, because the valid RAM itself is cleared only by its own reset.
- Sits between the core fetch/load port and the memory refill engine; the data RAM is handled elsewhere.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_line_ctrl_if.sv | 40 ++++
 rtl/cache_line_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split widths for the direct-mapped cache line controller.
`ifndef CACHE_INDEX_BITS
`define CACHE_INDEX_BITS 6
`endif
`ifndef CACHE_LINES
`define CACHE_LINES 64
`endif

package cache_pkg;

   localparam int IDX_BITS   = `CACHE_INDEX_BITS;
   localparam int LINE_COUNT = `CACHE_LINES;
   localparam int OFS_BITS   = 4;
   localparam int TAG_BITS   = 32 - IDX_BITS - OFS_BITS;

   typedef enum logic [2:0] {
      FLUSH,
      IDLE,
      LOOKUP,
      COMPARE,
      REFILL,
      UPDATE
   } state_t;

   typedef struct packed {
      logic [TAG_BITS-1:0] tag;
      logic [IDX_BITS-1:0] index;
      logic [OFS_BITS-1:0] offset;
   } addr_fields_t;

   function automatic addr_fields_t split_addr(input logic [31:0] addr);
      return addr_fields_t'(addr);
   endfunction

endpackage

// File: rtl/cache_line_ctrl_if.sv
// Pin bundle between the line controller, the core port, the valid/tag RAMs and the refill engine.
interface cache_line_ctrl_if #(
   parameter int INDEX_W = cache_pkg::IDX_BITS,
   parameter int TAG_W   = cache_pkg::TAG_BITS
);

   logic               core_req;
   logic [31:0]        core_addr;
   logic               core_ready;
   logic               core_done;
   logic               core_miss;
   logic               flush_req;
   logic               flush_busy;
   logic [INDEX_W-1:0] v_addr;
   logic               v_in;
   logic               v_write;
   logic               v_out;
   logic [INDEX_W-1:0] t_addr;
   logic [TAG_W-1:0]   t_in;
   logic               t_write;
   logic [TAG_W-1:0]   t_out;
   logic               mem_req;
   logic [31:0]        mem_addr;
   logic               mem_ack;

   modport master (
      input  core_req, core_addr, flush_req, v_out, t_out, mem_ack,
      output core_ready, core_done, core_miss, flush_busy,
             v_addr, v_in, v_write, t_addr, t_in, t_write,
             mem_req, mem_addr
   );

   modport slave (
      output core_req, core_addr, flush_req, v_out, t_out, mem_ack,
      input  core_ready, core_done, core_miss, flush_busy,
             v_addr, v_in, v_write, t_addr, t_in, t_write,
             mem_req, mem_addr
   );

endinterface

// File: rtl/cache_line_ctrl.sv
// Valid/tag RAM controller: hit/miss lookup, line refill handshake and full-cache invalidate sweep.
module cache_line_ctrl #(
   parameter int INDEX_W  = cache_pkg::IDX_BITS,
   parameter int LINES    = cache_pkg::LINE_COUNT,
   parameter int OFFSET_W = cache_pkg::OFS_BITS,
   parameter int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
   input  logic              clk,
   input  logic              rstn,
   cache_line_ctrl_if.master bus
);

   import cache_pkg::*;

   localparam logic [INDEX_W-1:0] LAST_LINE = INDEX_W'(LINES - 1);

   state_t             state_reg;
   logic [INDEX_W-1:0] cnt_reg;
   logic               flush_pend_reg;
   logic [TAG_W-1:0]   tag_reg;
   logic [INDEX_W-1:0] index_reg;

   logic [INDEX_W-1:0] v_addr_reg;
   logic               v_in_reg;
   logic               v_write_reg;
   logic [TAG_W-1:0]   t_in_reg;
   logic               t_write_reg;
   logic               core_done_reg;
   logic               core_miss_reg;
   logic               mem_req_reg;
   logic [31:0]        mem_addr_reg;
   logic               flush_busy_reg;

   addr_fields_t       req_fields;
   logic [OFFSET_W-1:0] unused_offset;

   assign req_fields    = split_addr(bus.core_addr);
   assign unused_offset = req_fields.offset;

   assign bus.core_ready = (state_reg == IDLE) && !bus.flush_req && !flush_pend_reg;
   assign bus.core_done  = core_done_reg;
   assign bus.core_miss  = core_miss_reg;
   assign bus.flush_busy = flush_busy_reg;
   assign bus.v_addr     = v_addr_reg;
   assign bus.v_in       = v_in_reg;
   assign bus.v_write    = v_write_reg;
   assign bus.t_addr     = v_addr_reg;
   assign bus.t_in       = t_in_reg;
   assign bus.t_write    = t_write_reg;
   assign bus.mem_req    = mem_req_reg;
   assign bus.mem_addr   = mem_addr_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= FLUSH;
         cnt_reg        <= '0;
         flush_pend_reg <= 1'b0;
         tag_reg        <= '0;
         index_reg      <= '0;
         v_addr_reg     <= '0;
         v_in_reg       <= 1'b0;
         v_write_reg    <= 1'b0;
         t_in_reg       <= '0;
         t_write_reg    <= 1'b0;
         core_done_reg  <= 1'b0;
         core_miss_reg  <= 1'b0;
         mem_req_reg    <= 1'b0;
         mem_addr_reg   <= '0;
         flush_busy_reg <= 1'b1;
      end else begin
         core_done_reg <= 1'b0;
         core_miss_reg <= 1'b0;
         v_write_reg   <= 1'b0;
         t_write_reg   <= 1'b0;

         case (state_reg)
            FLUSH: begin
               // The write of the last line is in flight this cycle, so the sweep is complete.
               if (v_write_reg && (v_addr_reg == LAST_LINE)) begin
                  state_reg      <= IDLE;
                  flush_busy_reg <= 1'b0;
               end else begin
                  v_addr_reg     <= cnt_reg;
                  v_in_reg       <= 1'b0;
                  v_write_reg    <= 1'b1;
                  cnt_reg        <= cnt_reg + INDEX_W'(1);
                  flush_busy_reg <= 1'b1;
               end
            end

            IDLE: begin
               if (bus.flush_req || flush_pend_reg) begin
                  // Issue line 0 on entry so the sweep is exactly LINES busy cycles.
                  flush_pend_reg <= 1'b0;
                  state_reg      <= FLUSH;
                  flush_busy_reg <= 1'b1;
                  v_addr_reg     <= cnt_reg;
                  v_in_reg       <= 1'b0;
                  v_write_reg    <= 1'b1;
                  cnt_reg        <= cnt_reg + INDEX_W'(1);
               end else if (bus.core_req) begin
                  tag_reg    <= req_fields.tag;
                  index_reg  <= req_fields.index;
                  v_addr_reg <= req_fields.index;
                  state_reg  <= LOOKUP;
               end
            end

            LOOKUP: begin
               state_reg <= COMPARE;
            end

            COMPARE: begin
               if (bus.v_out && (bus.t_out == tag_reg)) begin
                  core_done_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else begin
                  core_miss_reg <= 1'b1;
                  mem_req_reg   <= 1'b1;
                  mem_addr_reg  <= {tag_reg, index_reg, {OFFSET_W{1'b0}}};
                  state_reg     <= REFILL;
               end
            end

            REFILL: begin
               if (bus.mem_ack) begin
                  mem_req_reg   <= 1'b0;
                  v_addr_reg    <= index_reg;
                  v_in_reg      <= 1'b1;
                  v_write_reg   <= 1'b1;
                  t_in_reg      <= tag_reg;
                  t_write_reg   <= 1'b1;
                  core_done_reg <= 1'b1;
                  state_reg     <= UPDATE;
               end
            end

            UPDATE: begin
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= FLUSH;
            end
         endcase

         // A flush arriving mid-request waits until the request has finished.
         if (bus.flush_req && (state_reg inside {LOOKUP, COMPARE, REFILL, UPDATE})) begin
            flush_pend_reg <= 1'b1;
         end
      end
   end

endmodule
